// File: rtl/fetch_queue.sv
// Instruction prefetch stage: sequential fetch with one outstanding imem request,
// returned {pc, inst} pairs buffered in a small FIFO in front of the decoder.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    redirect_valid,
  input  logic [31:0]             redirect_pc,
  output logic                    imem_req_valid,
  output logic [31:0]             imem_req_addr,
  input  logic                    imem_req_ready,
  input  logic                    imem_rsp_valid,
  input  logic [31:0]             imem_rsp_inst,
  output logic                    deq_valid,
  input  logic                    deq_ready,
  output logic [31:0]             deq_pc,
  output logic [31:0]             deq_inst,
  output logic                    deq_misaligned,
  output logic [$clog2(DEPTH):0]  count,
  output logic [1:0]              dbg_state
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT         = 2'd1,
    ST_WAIT_DISCARD = 2'd2,
    ST_HALT         = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [31:0]     fetch_pc, fetch_pc_nxt;
  logic [31:0]     req_pc;
  logic [PW-1:0]   wr_ptr, rd_ptr;

  logic [31:0]     mem_pc   [DEPTH];
  logic [31:0]     mem_inst [DEPTH];
  logic            mem_mis  [DEPTH];

  logic            has_space, aligned, issue, enq, deq, enq_mis;
  logic [31:0]     enq_pc, enq_inst;

  // Handshakes are strict valid/ready: a transfer happens on a rising edge where
  // both are high, and the request address is held while imem_req_valid is high.
  assign has_space     = (count < CW'(DEPTH));
  assign aligned       = (fetch_pc[1:0] == 2'b00);
  assign imem_req_addr = fetch_pc;
  assign dbg_state     = state;

  assign deq_valid      = (count != '0);
  assign deq            = deq_valid && deq_ready && !redirect_valid;
  assign deq_pc         = deq_valid ? mem_pc[rd_ptr]   : 32'h0;
  assign deq_inst       = deq_valid ? mem_inst[rd_ptr] : 32'h0;
  assign deq_misaligned = deq_valid ? mem_mis[rd_ptr]  : 1'b0;

  always_comb begin
    state_nxt      = state;
    fetch_pc_nxt   = fetch_pc;
    imem_req_valid = 1'b0;
    issue          = 1'b0;
    enq            = 1'b0;
    enq_pc         = fetch_pc;
    enq_inst       = NOP_INST;
    enq_mis        = 1'b0;

    unique case (state)
      ST_IDLE: begin
        // rst gating keeps the request low for the whole time reset is held
        imem_req_valid = rst && has_space && !redirect_valid && aligned;
        if (imem_req_valid && imem_req_ready) begin
          issue        = 1'b1;
          fetch_pc_nxt = fetch_pc + 32'd4;
          state_nxt    = ST_WAIT;
        end else if (rst && !aligned && has_space && !redirect_valid) begin
          enq       = 1'b1;
          enq_mis   = 1'b1;
          state_nxt = ST_HALT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          enq       = 1'b1;
          enq_pc    = req_pc;
          enq_inst  = imem_rsp_inst;
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT_DISCARD: begin
        if (imem_rsp_valid) state_nxt = ST_IDLE;
      end
      ST_HALT: begin
        state_nxt = ST_HALT;
      end
    endcase

    // A redirect with a response still owed must swallow that response later.
    if (redirect_valid) begin
      enq          = 1'b0;
      fetch_pc_nxt = redirect_pc;
      if ((state == ST_WAIT || state == ST_WAIT_DISCARD) && !imem_rsp_valid)
        state_nxt = ST_WAIT_DISCARD;
      else
        state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      if (issue) req_pc <= fetch_pc;
      if (redirect_valid) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= wr_ptr + PW'(1);
        if (deq) rd_ptr <= rd_ptr + PW'(1);
        unique case ({enq, deq})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  // Payload storage needs no reset: every read is gated by count.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc[wr_ptr]   <= enq_pc;
      mem_inst[wr_ptr] <= enq_inst;
      mem_mis[wr_ptr]  <= enq_mis;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a memory responder, a dequeue monitor fed by an
// expected queue of {pc, inst, misaligned}, and inline checks of control outputs.
module tb_fetch_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] K     = 32'hA5A5A5A5;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_inst;
  logic        deq_valid;
  logic        deq_ready = 1'b0;
  logic [31:0] deq_pc;
  logic [31:0] deq_inst;
  logic        deq_misaligned;
  logic [2:0]  count;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];

  // memory model controls
  logic        mem_auto = 1'b0;
  logic        man_ready = 1'b0, man_rsp = 1'b0;
  logic [31:0] man_inst = 32'h0;
  logic        auto_ready = 1'b0, auto_rsp = 1'b0;
  logic [31:0] auto_inst = 32'h0;
  int          budget = 0;
  int          accepts = 0;
  logic [31:0] last_acc = 32'hFFFF_FFFF;

  assign imem_req_ready = mem_auto ? auto_ready : man_ready;
  assign imem_rsp_valid = mem_auto ? auto_rsp   : man_rsp;
  assign imem_rsp_inst  = mem_auto ? auto_inst  : man_inst;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_inst(imem_rsp_inst),
    .deq_valid(deq_valid), .deq_ready(deq_ready),
    .deq_pc(deq_pc), .deq_inst(deq_inst), .deq_misaligned(deq_misaligned),
    .count(count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] inst, input logic mis);
    exp_q.push_back({pc, inst, mis});
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n = 0;
    while (exp_q.size() != 0 && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, exp_q.size(), 0);
    step();
  endtask

  task automatic wait_count(input string name, input logic [2:0] target, input int limit);
    int n = 0;
    while (count !== target && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, count, target);
  endtask

  // zero-wait responder: accept while under budget, answer the next cycle with addr^K
  initial begin
    logic        a;
    logic [31:0] ad;
    forever begin
      @(negedge clk);
      a  = imem_req_valid && imem_req_ready;
      ad = imem_req_addr;
      if (a) last_acc = ad;
      if (a && mem_auto) accepts++;
      @(posedge clk);
      #1;
      auto_rsp   = a && mem_auto;
      auto_inst  = a ? (ad ^ K) : 32'h0;
      auto_ready = (accepts < budget);
    end
  end

  // scoreboard monitor: every dequeue handshake pops one expected entry
  initial begin
    logic [64:0] e;
    forever begin
      @(negedge clk);
      if (rst && deq_valid && deq_ready && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL deq_unexpected: got pc=%h inst=%h, expected no entry", deq_pc, deq_inst);
        end else begin
          e = exp_q.pop_front();
          check("deq_pc", deq_pc, e[64:33]);
          check("deq_inst", deq_inst, e[32:1]);
          check("deq_misaligned", {31'h0, deq_misaligned}, {31'h0, e[0]});
        end
      end
    end
  end

  initial begin
    // reset state
    #12;
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_deq_valid", deq_valid, 0);
    check("rst_deq_pc", deq_pc, 0);
    check("rst_deq_inst", deq_inst, 0);
    check("rst_deq_mis", deq_misaligned, 0);
    check("rst_count", count, 0);

    // 1: streaming fetch from reset with zero-wait memory
    mem_auto = 1'b1;
    budget = 4;
    deq_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(32'(i * 4), 32'(i * 4) ^ K, 1'b0);
    #5 rst = 1'b1;
    @(negedge clk);
    check("t1_first_req_valid", imem_req_valid, 1);
    check("t1_first_req_addr", imem_req_addr, 32'h0);
    wait_drain("t1_drain", 40);
    @(negedge clk);
    check("t1_next_req_addr", imem_req_addr, 32'd16);
    check("t1_last_acc", last_acc, 32'd12);
    check("t1_state_idle", dbg_state, 0);

    // 2: decoder stalled from reset fills the FIFO, then drains in order
    step();
    rst = 1'b0;
    deq_ready = 1'b0;
    budget = accepts + 5;
    for (int i = 0; i < 5; i++) push(32'(i * 4), 32'(i * 4) ^ K, 1'b0);
    #4 rst = 1'b1;
    wait_count("t2_full", 3'd4, 60);
    check("t2_full_no_req", imem_req_valid, 0);
    check("t2_head_pc", deq_pc, 32'h0);
    repeat (3) @(negedge clk);
    check("t2_full_still_no_req", imem_req_valid, 0);
    step();
    deq_ready = 1'b1;
    wait_drain("t2_drain", 60);
    @(negedge clk);
    check("t2_resume_acc", last_acc, 32'd16);
    check("t2_next_req_addr", imem_req_addr, 32'd20);

    // 3: redirect while waiting, stale response discarded
    step();
    mem_auto = 1'b0;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    check("t3_in_wait", dbg_state, 1);
    step();
    redirect_valid = 1'b0;
    man_rsp = 1'b1;
    man_inst = 32'hDEADBEEF;
    @(negedge clk);
    check("t3_wait_discard", dbg_state, 2);
    check("t3_discard_no_req", imem_req_valid, 0);
    step();
    man_rsp = 1'b0;
    @(negedge clk);
    check("t3_req_valid", imem_req_valid, 1);
    check("t3_req_addr", imem_req_addr, 32'h100);
    check("t3_count", count, 0);
    step();
    push(32'h100, 32'h100 ^ K, 1'b0);
    mem_auto = 1'b1;
    budget = accepts + 1;
    wait_drain("t3_drain", 40);

    // 4: redirect coinciding with the response
    mem_auto = 1'b0;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    man_rsp = 1'b1;
    man_inst = 32'h12345678;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    step();
    man_rsp = 1'b0;
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t4_count", count, 0);
    check("t4_deq_valid", deq_valid, 0);
    check("t4_state_idle", dbg_state, 0);
    check("t4_req_valid", imem_req_valid, 1);
    check("t4_req_addr", imem_req_addr, 32'h200);
    step();
    push(32'h200, 32'h200 ^ K, 1'b0);
    mem_auto = 1'b1;
    budget = accepts + 1;
    wait_drain("t4_drain", 40);

    // 5: misaligned redirect yields one marker entry and halts fetch
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    push(32'h102, NOP, 1'b1);
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    check("t5_no_req", imem_req_valid, 0);
    step();
    @(negedge clk);
    check("t5_halt", dbg_state, 3);
    check("t5_marker_count", count, 1);
    repeat (3) step();
    @(negedge clk);
    check("t5_halt_no_req", imem_req_valid, 0);
    check("t5_halt_stays", dbg_state, 3);
    check("t5_empty", count, 0);
    step();
    budget = accepts + 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h300;
    push(32'h300, 32'h300 ^ K, 1'b0);
    step();
    redirect_valid = 1'b0;
    wait_drain("t5_drain", 40);
    check("t5_resume_acc", last_acc, 32'h300);

    // 6: asynchronous reset mid-wait with three entries held
    deq_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h400;
    budget = accepts + 3;
    step();
    redirect_valid = 1'b0;
    wait_count("t6_three", 3'd3, 60);
    step();
    mem_auto = 1'b0;
    man_ready = 1'b1;
    step();
    man_ready = 1'b0;
    @(negedge clk);
    check("t6_in_wait", dbg_state, 1);
    check("t6_count3", count, 3);
    #2 rst = 1'b0;
    #1;
    check("t6_rst_req_valid", imem_req_valid, 0);
    check("t6_rst_deq_valid", deq_valid, 0);
    check("t6_rst_deq_pc", deq_pc, 0);
    check("t6_rst_deq_inst", deq_inst, 0);
    check("t6_rst_count", count, 0);
    check("t6_rst_state", dbg_state, 0);
    step();
    rst = 1'b1;
    man_rsp = 1'b1;
    man_inst = 32'hBADC0DE0;
    @(negedge clk);
    check("t6_req_valid", imem_req_valid, 1);
    check("t6_req_addr", imem_req_addr, 32'h0);
    step();
    man_rsp = 1'b0;
    @(negedge clk);
    check("t6_late_rsp_ignored", count, 0);
    check("t6_late_no_deq", deq_valid, 0);
    step();
    deq_ready = 1'b1;
    push(32'h0, 32'h0 ^ K, 1'b0);
    mem_auto = 1'b1;
    budget = accepts + 1;
    wait_drain("t6_drain", 40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
